// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and the buffered result entry layout.
package alu_pkg;

    localparam int NUM_FLAGS = 6;

    localparam int FLG_CARRY = 0;
    localparam int FLG_OVF   = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_LESS  = 3;
    localparam int FLG_EQ    = 4;
    localparam int FLG_ZERO  = 5;

    localparam int ENTRY_RES_W = 8;
    localparam int ENTRY_SEL_W = 5;

    typedef struct packed {
        logic [ENTRY_RES_W-1:0] result;
        logic [ENTRY_SEL_W-1:0] select;
        logic [NUM_FLAGS-1:0]   flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer handshake bundle between the ALU, the result buffer and its consumer.
interface alu_result_buffer_if #(
    parameter int RES_W = 8,
    parameter int SEL_W = 5
) ();
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [RES_W-1:0]     in_result;
    logic [SEL_W-1:0]     in_select;
    logic [NUM_FLAGS-1:0] in_flags;

    logic                 out_valid;
    logic                 out_ready;
    logic [RES_W-1:0]     out_result;
    logic [SEL_W-1:0]     out_select;
    logic [NUM_FLAGS-1:0] out_flags;

    modport slave (
        input  in_valid, in_result, in_select, in_flags, out_ready,
        output in_ready, out_valid, out_result, out_select, out_flags
    );

    modport master (
        output in_valid, in_result, in_select, in_flags, out_ready,
        input  in_ready, out_valid, out_result, out_select, out_flags
    );

endinterface

// File: rtl/alu_result_buffer_sync_fifo.sv
// Generic single-clock circular FIFO with an explicit occupancy register.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       push_fire
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_fire;

    // Status decodes only from the registered count, so push_ready never sees pop_ready.
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: FIFOs result/opcode/flags for a stalling consumer and tracks sticky flags and op count.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = 8,
    parameter int SEL_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_result_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [NUM_FLAGS-1:0]   sticky_flags,
    input  logic                   sticky_clr,
    output logic [CNT_W-1:0]       op_count
);
    localparam int ENTRY_W = RES_W + SEL_W + NUM_FLAGS;

    alu_entry_t         wr_entry;
    alu_entry_t         rd_entry;
    logic [ENTRY_W-1:0] rd_bits;
    logic               push;

    assign wr_entry.result = bus.in_result;
    assign wr_entry.select = bus.in_select;
    assign wr_entry.flags  = bus.in_flags;
    assign rd_entry        = alu_entry_t'(rd_bits);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  (ENTRY_W'(wr_entry)),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (rd_bits),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .push_fire  (push)
    );

    assign bus.out_result = rd_entry.result;
    assign bus.out_select = rd_entry.select;
    assign bus.out_flags  = rd_entry.flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else begin
            // A clear coinciding with a push keeps only the newly pushed flags.
            if (sticky_clr) sticky_flags <= push ? bus.in_flags : '0;
            else if (push)  sticky_flags <= sticky_flags | bus.in_flags;
            if (push && (op_count != '1)) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized scoreboard bench for alu_result_buffer with directed corner sequences.
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int RES_W = 8;
    localparam int SEL_W = 5;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sticky_clr;
    logic [$clog2(DEPTH):0] count;
    logic full, empty;
    logic [NUM_FLAGS-1:0] sticky_flags;
    logic [CNT_W-1:0] op_count;

    int errors = 0;
    int checks = 0;

    alu_result_buffer_if #(.RES_W(RES_W), .SEL_W(SEL_W)) ab ();

    alu_result_buffer #(
        .DEPTH (DEPTH),
        .RES_W (RES_W),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ab.slave),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned res;
        int unsigned sel;
        int unsigned flg;
    } exp_t;

    exp_t        sb_q[$];
    int          mdl_cnt = 0;
    int unsigned mdl_sticky = 0;
    int unsigned mdl_ops = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides acceptance from its own occupancy and queues the expected entries.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mdl_cnt    = 0;
            mdl_sticky = 0;
            mdl_ops    = 0;
        end else begin
            bit acc, take;
            acc  = ab.in_valid && (mdl_cnt < DEPTH);
            take = (mdl_cnt > 0) && ab.out_ready;
            if (acc) begin
                exp_t e;
                e.res = ab.in_result;
                e.sel = ab.in_select;
                e.flg = ab.in_flags;
                sb_q.push_back(e);
                if (mdl_ops < (2**CNT_W - 1)) mdl_ops++;
            end
            if (sticky_clr) mdl_sticky = acc ? ab.in_flags : 0;
            else if (acc)   mdl_sticky = mdl_sticky | ab.in_flags;
            mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (take ? 1 : 0);
        end
    end

    // Monitor: compares status every cycle and the head entry whenever it is consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count, mdl_cnt);
            chk("full", full, mdl_cnt == DEPTH);
            chk("empty", empty, mdl_cnt == 0);
            chk("in_ready", ab.in_ready, mdl_cnt < DEPTH);
            chk("out_valid", ab.out_valid, mdl_cnt > 0);
            chk("sticky_flags", sticky_flags, mdl_sticky);
            chk("op_count", op_count, mdl_ops);
            if (ab.out_valid && ab.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_without_expected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("out_result", ab.out_result, e.res);
                    chk("out_select", ab.out_select, e.sel);
                    chk("out_flags", ab.out_flags, e.flg);
                end
            end
        end
    end

    task automatic cyc(input bit v, input int unsigned res, input int unsigned sel,
                       input int unsigned flg, input bit ordy, input bit clr);
        ab.in_valid  = v;
        ab.in_result = RES_W'(res);
        ab.in_select = SEL_W'(sel);
        ab.in_flags  = NUM_FLAGS'(flg);
        ab.out_ready = ordy;
        sticky_clr   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        ab.in_valid = 0; ab.in_result = '0; ab.in_select = '0; ab.in_flags = '0;
        ab.out_ready = 0; sticky_clr = 0;

        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", ab.in_ready, 1);
        chk("rst_out_valid", ab.out_valid, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_op_count", op_count, 0);
        @(posedge clk); #2;
        rst_n = 1;

        // Single push, then fill to full and try an overflow push.
        cyc(1, 21, 0, 0, 0, 0);
        cyc(1, 8'hFF, 3, 6'h02, 0, 0);
        cyc(1, 110, 7, 6'h04, 0, 0);
        cyc(1, 1, 31, 6'h08, 0, 0);
        cyc(1, 7, 9, 6'h3F, 0, 0);
        // Full with simultaneous pop and push: push refused.
        cyc(1, 7, 9, 6'h3F, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        drain();

        // Stream 10 entries with the consumer always ready.
        for (int i = 0; i < 10; i++) cyc(1, 40 + i, i, i, 1, 0);
        drain();

        // Sticky accumulation and clear-with-push.
        cyc(1, 2, 1, 6'b000001, 1, 0);
        cyc(1, 3, 2, 6'b010000, 1, 0);
        cyc(1, 4, 3, 6'b100000, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        drain();

        // Asynchronous reset with three entries held.
        cyc(1, 10, 1, 1, 0, 0);
        cyc(1, 11, 2, 2, 0, 0);
        cyc(1, 12, 3, 4, 0, 0);
        #1 rst_n = 0;
        #1;
        chk("async_empty", empty, 1);
        chk("async_out_valid", ab.out_valid, 0);
        chk("async_op_count", op_count, 0);
        chk("async_count", count, 0);
        @(posedge clk); #2;
        rst_n = 1;

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 31),
                $urandom_range(0, 63), $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        drain();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
